// File: rtl/ibex_soc_pkg.sv
// Shared types and constants for the ibex SoC memory fabric: arbitration
// owners, downstream targets and the default address map.
package ibex_soc_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } arb_owner_e;

    typedef enum logic [1:0] {
        TGT_RAM   = 2'd0,
        TGT_HWREG = 2'd1,
        TGT_MISS  = 2'd2
    } mem_target_e;

    localparam logic [31:0] RAM_BASE       = 32'h0000_0000;
    localparam logic [15:0] HWREG_PAGE_DEF = 16'hFF00;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: maps a granted address and requester type
// onto RAM, the hwreg page (data side only) or a miss.
module mem_addr_decode
    import ibex_soc_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 262144,
    parameter logic [15:0] HWREG_PAGE = HWREG_PAGE_DEF
) (
    input  logic [31:0] i_addr,
    input  logic        i_is_data,
    output mem_target_e o_target
);

    localparam logic [31:0] RAM_MASK = 32'(RAM_SIZE - 1);

    always_comb begin
        o_target = TGT_MISS;
        if ((i_addr & ~RAM_MASK) == RAM_BASE) begin
            o_target = TGT_RAM;
        end else if (i_is_data && (i_addr[31:16] == HWREG_PAGE)) begin
            o_target = TGT_HWREG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (ibex fetch / LSU) arbiter onto a RAM port and a hwreg port.
// Define MEM_ARB_STARVE_GUARD_EN to add the instruction starvation guard.
module mem_arbiter
    import ibex_soc_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 262144,
    parameter logic [15:0] HWREG_PAGE = HWREG_PAGE_DEF,
    parameter int unsigned MAX_STALL  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i,

    output logic        hwreg_req_o,
    output logic        hwreg_we_o,
    output logic [15:0] hwreg_addr_o,
    output logic [31:0] hwreg_wdata_o,
    input  logic        hwreg_rvalid_i,
    input  logic [31:0] hwreg_rdata_i
);

    logic        w_instr_gnt;
    logic        w_data_gnt;
    logic        w_any_gnt;
    logic        w_force_instr;
    logic [31:0] w_addr;
    mem_target_e w_target;
    logic        w_resp_ok;
    logic [31:0] w_resp_data;

    arb_owner_e  r_owner;
    mem_target_e r_target;
    logic        r_we;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

    logic [3:0] r_stall_cnt;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (!instr_req_i || w_instr_gnt) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != STALL_LIMIT) begin
            r_stall_cnt <= r_stall_cnt + 4'd1;
        end
    end

    assign w_force_instr = (r_stall_cnt == STALL_LIMIT);
`else
    assign w_force_instr = 1'b0;
`endif

    // Grants are held off while reset is asserted so nothing leaks downstream.
    // NOTE: every always_comb output is defaulted first so no latch is inferred.
    always_comb begin
        w_instr_gnt = 1'b0;
        w_data_gnt  = 1'b0;
        if (rst_ni) begin
            if (instr_req_i && (w_force_instr || !data_req_i)) begin
                w_instr_gnt = 1'b1;
            end else if (data_req_i) begin
                w_data_gnt = 1'b1;
            end
        end
    end

    assign w_any_gnt   = w_instr_gnt | w_data_gnt;
    assign w_addr      = w_data_gnt ? data_addr_i : instr_addr_i;
    assign instr_gnt_o = w_instr_gnt;
    assign data_gnt_o  = w_data_gnt;

    mem_addr_decode #(
        .RAM_SIZE   (RAM_SIZE),
        .HWREG_PAGE (HWREG_PAGE)
    ) u_decode (
        .i_addr    (w_addr),
        .i_is_data (w_data_gnt),
        .o_target  (w_target)
    );

    assign ram_req_o     = w_any_gnt && (w_target == TGT_RAM);
    assign ram_we_o      = ram_req_o && w_data_gnt && data_we_i;
    assign ram_be_o      = !ram_req_o ? 4'h0 : (w_data_gnt ? data_be_i : 4'hF);
    assign ram_addr_o    = ram_req_o ? w_addr : 32'h0;
    assign ram_wdata_o   = (ram_req_o && w_data_gnt) ? data_wdata_i : 32'h0;

    assign hwreg_req_o   = w_any_gnt && (w_target == TGT_HWREG);
    assign hwreg_we_o    = hwreg_req_o && data_we_i;
    assign hwreg_addr_o  = hwreg_req_o ? w_addr[15:0] : 16'h0;
    assign hwreg_wdata_o = hwreg_req_o ? data_wdata_i : 32'h0;

    // Response tracker reloads every cycle; a cycle without a grant leaves no owner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner  <= OWN_NONE;
            r_target <= TGT_MISS;
            r_we     <= 1'b0;
        end else begin
            r_owner  <= w_data_gnt ? OWN_DATA : (w_instr_gnt ? OWN_INSTR : OWN_NONE);
            r_target <= w_target;
            r_we     <= w_data_gnt && data_we_i;
        end
    end

    always_comb begin
        w_resp_ok   = 1'b0;
        w_resp_data = 32'h0;
        case (r_target)
            TGT_RAM: begin
                w_resp_ok   = ram_rvalid_i;
                w_resp_data = ram_rdata_i;
            end
            TGT_HWREG: begin
                w_resp_ok   = hwreg_rvalid_i;
                w_resp_data = hwreg_rdata_i;
            end
            default: ;
        endcase
        if (r_we || !w_resp_ok) begin
            w_resp_data = 32'h0;
        end
    end

    assign instr_rvalid_o = (r_owner == OWN_INSTR);
    assign instr_err_o    = instr_rvalid_o && !w_resp_ok;
    assign instr_rdata_o  = instr_rvalid_o ? w_resp_data : 32'h0;

    assign data_rvalid_o  = (r_owner == OWN_DATA);
    assign data_err_o     = data_rvalid_o && !w_resp_ok;
    assign data_rdata_o   = data_rvalid_o ? w_resp_data : 32'h0;

endmodule
